// File: rtl/adderc_mp_if.sv
// Word-serial handshake bundle for the multi-precision adder/subtractor.
// The design drives the slave side and the producer/consumer drives the master side.
interface adderc_mp_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic             sub_nadd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_last;
  logic             cout;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, in_first, in_last, sub_nadd, a, b, out_ready,
    input  in_ready, out_valid, out, out_last, cout, ovf, err
  );

  modport slave (
    input  in_valid, in_first, in_last, sub_nadd, a, b, out_ready,
    output in_ready, out_valid, out, out_last, cout, ovf, err
  );
endinterface

// File: rtl/adderc_mp.sv
// Multi-precision add/subtract over word streams, least significant word first.
// Signed overflow reporting is built in only when ADDERC_MP_OVF_EN is defined.
module adderc_mp #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        enable,
  adderc_mp_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             op_q;
  logic             carry_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             out_last_q;
  logic             cout_q;
  logic             err_q;

  logic             in_fire;
  logic             out_fire;
  logic             produce;
  logic             op_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // A new word may enter whenever the single output slot is empty or draining this cycle.
  assign bus.in_ready = srst_n & enable & (~out_valid_q | bus.out_ready);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = out_valid_q & bus.out_ready & enable;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    op_eff  = bus.in_first ? bus.sub_nadd : op_q;
    cin_eff = bus.in_first ? bus.sub_nadd : carry_q;
    produce = in_fire & (bus.in_first | (state == RUN));
    b_eff   = bus.b ^ {WIDTH{op_eff}};
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
  end

`ifdef ADDERC_MP_OVF_EN
  logic msb_cin;
  logic ovf_q;

  // Carry into the MSB recovered from the MSB sum bit.
  assign msb_cin = bus.a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      ovf_q <= 1'b0;
    end else if (produce && bus.in_last) begin
      ovf_q <= msb_cin ^ sum[WIDTH];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state       <= IDLE;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (enable) begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      if (in_fire) begin
        // A new first word inside a running op abandons the old op.
        if (bus.in_first && state == RUN) begin
          err_q <= 1'b1;
        end
        if (produce) begin
          op_q        <= op_eff;
          carry_q     <= sum[WIDTH];
          out_valid_q <= 1'b1;
          out_q       <= sum[WIDTH-1:0];
          out_last_q  <= bus.in_last;
          if (bus.in_last) begin
            cout_q <= sum[WIDTH];
          end
          state <= bus.in_last ? IDLE : RUN;
        end else begin
          // Orphan continuation word: swallowed, no seed to continue from.
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_last  = out_last_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_adderc_mp.sv
// Directed bench for adderc_mp at WIDTH=16; expected values are worked out by hand.
// Overflow expectation follows whether ADDERC_MP_OVF_EN is defined for the build.
module tb_adderc_mp;
  localparam int WIDTH = 16;

`ifdef ADDERC_MP_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst_n;
  logic enable;
  int   checks = 0;
  int   failures = 0;

  adderc_mp_if #(.WIDTH(WIDTH)) bus_if ();

  adderc_mp #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .enable (enable),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic s,
                       input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bus_if.in_valid = 1'b1;
    bus_if.in_first = f;
    bus_if.in_last  = l;
    bus_if.sub_nadd = s;
    bus_if.a        = av;
    bus_if.b        = bv;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
    bus_if.in_first = 1'b0;
    bus_if.in_last  = 1'b0;
    bus_if.sub_nadd = 1'b0;
    bus_if.a        = '0;
    bus_if.b        = '0;
  endtask

  initial begin
    srst_n           = 1'b0;
    enable           = 1'b1;
    bus_if.out_ready = 1'b1;
    idle();
    cyc();
    cyc();
    check("rst_in_ready", 32'(bus_if.in_ready), 0);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_out", 32'(bus_if.out), 0);
    check("rst_cout", 32'(bus_if.cout), 0);
    check("rst_ovf", 32'(bus_if.ovf), 0);
    check("rst_err", 32'(bus_if.err), 0);
    srst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus_if.in_ready), 1);

    // Single-word add 1+2
    drive(1, 1, 0, 16'h0001, 16'h0002);
    cyc();
    check("add1_valid", 32'(bus_if.out_valid), 1);
    check("add1_out", 32'(bus_if.out), 32'h0003);
    check("add1_last", 32'(bus_if.out_last), 1);
    check("add1_cout", 32'(bus_if.cout), 0);
    check("add1_err", 32'(bus_if.err), 0);
    idle();
    cyc();
    check("add1_drain", 32'(bus_if.out_valid), 0);

    // Two-word add 0x0000FFFF + 0x00000001
    drive(1, 0, 0, 16'hFFFF, 16'h0001);
    cyc();
    check("add2_w0", 32'(bus_if.out), 32'h0000);
    check("add2_w0_last", 32'(bus_if.out_last), 0);
    drive(0, 1, 0, 16'h0000, 16'h0000);
    cyc();
    check("add2_w1", 32'(bus_if.out), 32'h0001);
    check("add2_w1_last", 32'(bus_if.out_last), 1);
    check("add2_cout", 32'(bus_if.cout), 0);

    // Two-word sub 0x00010000 - 0x00000001
    drive(1, 0, 1, 16'h0000, 16'h0001);
    cyc();
    check("sub2_w0", 32'(bus_if.out), 32'hFFFF);
    drive(0, 1, 0, 16'h0001, 16'h0000);
    cyc();
    check("sub2_w1", 32'(bus_if.out), 32'h0000);
    check("sub2_w1_last", 32'(bus_if.out_last), 1);
    check("sub2_cout", 32'(bus_if.cout), 1);

    // Single-word 0 - 1 borrows
    drive(1, 1, 1, 16'h0000, 16'h0001);
    cyc();
    check("sub1_out", 32'(bus_if.out), 32'hFFFF);
    check("sub1_cout", 32'(bus_if.cout), 0);

    // Three-word add with a three-cycle output stall after the first word
    drive(1, 0, 0, 16'hFFFF, 16'h0001);
    cyc();
    check("add3_w0", 32'(bus_if.out), 32'h0000);
    bus_if.out_ready = 1'b0;
    drive(0, 0, 0, 16'h1234, 16'h0000);
    #1;
    check("stall_in_ready", 32'(bus_if.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_valid", 32'(bus_if.out_valid), 1);
      check("stall_out", 32'(bus_if.out), 32'h0000);
      check("stall_last", 32'(bus_if.out_last), 0);
    end
    bus_if.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus_if.in_ready), 1);
    cyc();
    check("add3_w1", 32'(bus_if.out), 32'h1235);
    check("add3_w1_last", 32'(bus_if.out_last), 0);
    drive(0, 1, 0, 16'hFFFF, 16'h0001);
    cyc();
    check("add3_w2", 32'(bus_if.out), 32'h0000);
    check("add3_w2_last", 32'(bus_if.out_last), 1);
    check("add3_cout", 32'(bus_if.cout), 1);
    idle();
    cyc();
    check("add3_drain", 32'(bus_if.out_valid), 0);

    // Enable low freezes a pending word and blocks input
    drive(1, 1, 0, 16'h0005, 16'h0006);
    cyc();
    check("en_w0", 32'(bus_if.out), 32'h000B);
    enable = 1'b0;
    drive(1, 1, 0, 16'h0007, 16'h0007);
    #1;
    check("en_low_in_ready", 32'(bus_if.in_ready), 0);
    cyc();
    cyc();
    check("en_low_valid", 32'(bus_if.out_valid), 1);
    check("en_low_out", 32'(bus_if.out), 32'h000B);
    enable = 1'b1;
    cyc();
    check("en_resume_out", 32'(bus_if.out), 32'h000E);
    idle();
    cyc();

    // Reset mid-op, then an orphan continuation word
    drive(1, 0, 0, 16'h1111, 16'h2222);
    cyc();
    check("mid_w0", 32'(bus_if.out), 32'h3333);
    srst_n = 1'b0;
    idle();
    cyc();
    check("mid_rst_valid", 32'(bus_if.out_valid), 0);
    check("mid_rst_in_ready", 32'(bus_if.in_ready), 0);
    srst_n = 1'b1;
    drive(0, 1, 0, 16'h0001, 16'h0001);
    cyc();
    check("orphan_valid", 32'(bus_if.out_valid), 0);
    check("orphan_err", 32'(bus_if.err), 1);
    idle();
    cyc();
    check("orphan_still_idle", 32'(bus_if.out_valid), 0);

    // First word arriving inside a running op reseeds and flags err
    srst_n = 1'b0;
    cyc();
    check("rst2_err", 32'(bus_if.err), 0);
    srst_n = 1'b1;
    drive(1, 0, 0, 16'h0001, 16'h0001);
    cyc();
    check("reseed_w0", 32'(bus_if.out), 32'h0002);
    check("reseed_w0_err", 32'(bus_if.err), 0);
    drive(1, 1, 0, 16'h0003, 16'h0004);
    cyc();
    check("reseed_out", 32'(bus_if.out), 32'h0007);
    check("reseed_last", 32'(bus_if.out_last), 1);
    check("reseed_err", 32'(bus_if.err), 1);

    // Signed overflow 0x7FFF + 1
    drive(1, 1, 0, 16'h7FFF, 16'h0001);
    cyc();
    check("ovf_out", 32'(bus_if.out), 32'h8000);
    check("ovf_cout", 32'(bus_if.cout), 0);
    check("ovf_flag", 32'(bus_if.ovf), 32'(OVF_EXP));
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adderc_mp.md
ADDERC_MP -- requirements
Module: adderc_mp

Interface
REQ-001 SHALL have parameter: WIDTH, 16, word width of each operand/result chunk (WIDTH >= 2).
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: srst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: enable  input  1  global advance enable; low freezes all state.
REQ-005 SHALL have ports: in_valid  input  1; in_ready  output  1; input word handshake.
REQ-006 SHALL have ports: in_first  input  1; in_last  input  1; operation delimiters, LSW first.
REQ-007 SHALL have ports: sub_nadd  input  1  0=a+b, 1=a-b; sampled on first word only.
REQ-008 SHALL have ports: a, b  input  WIDTH  operand words.
REQ-009 SHALL have ports: out_valid  output  1; out_ready  input  1; result word handshake.
REQ-010 SHALL have ports: out  output  WIDTH; out_last  output  1  result word, last marker.
REQ-011 SHALL have ports: cout  output  1; ovf  output  1; err  output  1  (err sticky).

Function
REQ-012 Input transfer SHALL occur when in_valid & in_ready & enable; output transfer when out_valid & out_ready & enable.
REQ-013 in_ready SHALL equal enable & (!out_valid | out_ready); one-word output register, latency 1 cycle, full throughput.
REQ-014 FSM states IDLE and RUN; reset -> IDLE.
REQ-015 Word with in_first accepted (any state): op latched from sub_nadd, carry seed = sub_nadd, b inverted if sub; result out = a + (b^{WIDTH{op}}) + seed mod 2^WIDTH; next carry stored.
REQ-016 Non-first word in RUN: same sum with stored op and stored carry.
REQ-017 Transitions: accepted word with in_last -> IDLE; else -> RUN; in_first & in_last = single-word op, stays IDLE.
REQ-018 in_first received in RUN SHALL reseed (treated as new op), abandon previous op (no last emitted) and set err.
REQ-019 Non-first word received in IDLE SHALL be accepted and dropped (no output), set err.
REQ-020 out_last SHALL mirror in_last of the producing word; cout and ovf SHALL be updated only with last word, held otherwise, meaningful when out_valid & out_last.
REQ-021 cout = carry out of MSW; for subtract, cout=1 means no borrow (a >= b unsigned).
REQ-022 Outputs (out, out_last, cout, ovf, out_valid) SHALL be held stable while out_valid & !out_ready.
REQ-023 enable low SHALL freeze FSM, carry, output registers; no transfers either side.

Reset
REQ-024 srst_n low at a rising edge SHALL force: state IDLE, carry 0, out_valid 0, out 0, out_last 0, cout 0, ovf 0, err 0; in_ready 0 during reset.
REQ-025 Reset mid-operation SHALL discard partial op and pending output word; no output follows until new in_first.
REQ-026 srst_n SHALL override enable.

Configuration
REQ-027 Macro ADDERC_MP_OVF_EN: defined -> ovf = signed two's-complement overflow of full multi-word result (carry into MSB xor carry out of MSB, last word); undefined -> ovf tied 0, no overflow logic.

Verification (WIDTH=16)
REQ-028 Single word add a=1,b=2,first,last -> out=0x0003, out_last=1, cout=0, err=0, one cycle later.
REQ-029 Two-word add 0x0000FFFF+0x00000001 -> words 0x0000 then 0x0001 (last), cout=0.
REQ-030 Two-word sub 0x00010000-0x00000001 -> words 0xFFFF then 0x0000 (last), cout=1; 0-1 single word -> 0xFFFF, cout=0.
REQ-031 Hold out_ready=0 three cycles during 3-word add -> in_ready=0, out word/flags stable, all words delivered in order after release.
REQ-032 srst_n=0 after first of 2-word op, then send non-first word -> out_valid=0, word dropped, err=1.
REQ-033 Single word 0x7FFF+0x0001 -> out=0x8000, ovf=1 with ADDERC_MP_OVF_EN, ovf=0 without.
